// File: rtl/drum_acc.sv
// rtl/drum_acc.sv - saturating run accumulator for signed DRUM multiplier products
// Sums a programmed number of products, then holds the result on a valid/ready port.
module drum_acc #(
  parameter int PW = 8,
  parameter int AW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          p_valid,
  input  logic [PW-1:0] p_data,
  output logic          p_ready,
  output logic          acc_valid,
  output logic [AW-1:0] acc_data,
  input  logic          acc_ready,
  output logic          busy,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [AW:0] SAT_MAX = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {2'b11, {(AW-1){1'b0}}};

  state_t        state, state_nxt;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ovf_q, ovf_nxt;
  logic signed [AW:0] sum;

  // One guard bit above AW so the raw sum never wraps before clamping.
  assign sum = $signed({acc[AW-1], acc}) + $signed({{(AW+1-PW){p_data[PW-1]}}, p_data});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_q;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = len;
          state_nxt = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (p_valid) begin
          if (sum > SAT_MAX) begin
            acc_nxt = SAT_MAX[AW-1:0];
            ovf_nxt = 1'b1;
          end else if (sum < SAT_MIN) begin
            acc_nxt = SAT_MIN[AW-1:0];
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = sum[AW-1:0];
          end
          cnt_nxt = cnt - 1'b1;
          if (cnt == {{(CW-1){1'b0}}, 1'b1}) state_nxt = DONE;
        end
      end
      DONE: begin
        if (acc_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign p_ready   = (state == ACC);
  assign acc_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_data  = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_drum_acc.sv
// tb/tb_drum_acc.sv - directed self-checking bench for drum_acc
// Runs with AW=10 so saturation is reachable with short runs of 8-bit products.
module tb_drum_acc;

  localparam int PW = 8;
  localparam int AW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] len;
  logic          p_valid;
  logic [PW-1:0] p_data;
  logic          p_ready;
  logic          acc_valid;
  logic [AW-1:0] acc_data;
  logic          acc_ready;
  logic          busy;
  logic          ovf;

  int tests = 0;
  int fails = 0;

  drum_acc #(.PW(PW), .AW(AW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .p_valid   (p_valid),
    .p_data    (p_data),
    .p_ready   (p_ready),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .acc_ready (acc_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_run(input logic [CW-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [PW-1:0] d);
    p_valid = 1'b1;
    p_data  = d;
    tick();
    p_valid = 1'b0;
  endtask

  task automatic take(input string tag);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk({tag, "_busy_after_take"}, busy, 0);
    chk({tag, "_valid_after_take"}, acc_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0;
    p_valid = 1'b0; p_data = '0; acc_ready = 1'b0;
    #2;
    chk("rst_p_ready", p_ready, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_data", acc_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Test 1: basic run
    begin_run(8'd3);
    chk("t1_p_ready", p_ready, 1);
    chk("t1_busy", busy, 1);
    push(8'h05);
    chk("t1_acc1", acc_data, 10'h005);
    push(8'hFD);
    chk("t1_acc2", acc_data, 10'h002);
    chk("t1_no_valid_yet", acc_valid, 0);
    push(8'h0A);
    chk("t1_valid", acc_valid, 1);
    chk("t1_sum", acc_data, 10'h00C);
    chk("t1_p_ready_done", p_ready, 0);
    chk("t1_ovf", ovf, 0);
    take("t1");

    // Test 2: stalls
    begin_run(8'd2);
    push(8'h10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_gap_acc", acc_data, 10'h010);
      chk("t2_gap_valid", acc_valid, 0);
      chk("t2_gap_ready", p_ready, 1);
    end
    push(8'h20);
    chk("t2_valid", acc_valid, 1);
    chk("t2_sum", acc_data, 10'h030);
    take("t2");

    // Test 3: positive saturation, negative saturation, ovf clear
    begin_run(8'd5);
    for (int i = 0; i < 4; i++) push(8'h7F);
    chk("t3_acc4", acc_data, 10'h1FC);
    chk("t3_ovf_before", ovf, 0);
    push(8'h7F);
    chk("t3_pos_sat", acc_data, 10'h1FF);
    chk("t3_pos_ovf", ovf, 1);
    take("t3a");
    chk("t3_ovf_sticky_idle", ovf, 1);
    begin_run(8'd5);
    chk("t3_ovf_cleared_start", ovf, 0);
    for (int i = 0; i < 5; i++) push(8'h80);
    chk("t3_neg_sat", acc_data, 10'h200);
    chk("t3_neg_ovf", ovf, 1);
    take("t3b");
    begin_run(8'd6);
    for (int i = 0; i < 5; i++) push(8'h7F);
    push(8'h80);
    chk("t3_unclamp", acc_data, 10'h17F);
    chk("t3_unclamp_ovf", ovf, 1);
    take("t3c");
    begin_run(8'd1);
    push(8'h01);
    chk("t3_small", acc_data, 10'h001);
    chk("t3_small_ovf", ovf, 0);
    take("t3d");

    // Test 4: zero length and backpressure
    begin_run(8'd0);
    chk("t4_valid", acc_valid, 1);
    chk("t4_data", acc_data, 0);
    chk("t4_busy", busy, 1);
    p_valid = 1'b1; p_data = 8'h05;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_valid", acc_valid, 1);
      chk("t4_hold_data", acc_data, 0);
      chk("t4_hold_p_ready", p_ready, 0);
    end
    p_valid = 1'b0;
    take("t4");

    // Test 5a: start ignored in ACC and DONE
    begin_run(8'd2);
    start = 1'b1; len = 8'd5;
    push(8'h04);
    start = 1'b0;
    chk("t5_acc1", acc_data, 10'h004);
    push(8'h04);
    chk("t5_orig_len_valid", acc_valid, 1);
    chk("t5_orig_len_sum", acc_data, 10'h008);
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    chk("t5_done_start_ignored", acc_valid, 1);
    chk("t5_done_data_kept", acc_data, 10'h008);
    take("t5a");

    // Test 5b: reset aborts a run
    begin_run(8'd4);
    push(8'h07);
    push(8'h07);
    chk("t5_partial", acc_data, 10'h00E);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_p_ready", p_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_acc_data", acc_data, 0);
    chk("t5_rst_acc_valid", acc_valid, 0);
    chk("t5_rst_ovf", ovf, 0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("t5_idle_after_rst", busy, 0);
    begin_run(8'd1);
    push(8'h03);
    chk("t5_fresh_valid", acc_valid, 1);
    chk("t5_fresh_sum", acc_data, 10'h003);
    take("t5b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/drum_acc.md
Name: drum_acc

Overview:
Sequential accumulator directly downstream of the DRUM approximate multiplier. It consumes a run of signed products over a valid/ready handshake and sums a programmed number of them into a saturating accumulator. It then presents the result on a valid/ready output port. Together with the multiplier it forms an approximate dot-product/MAC datapath behind the TinyTapeout pin wrapper.

Parameters:
PW, 8, product width in bits (equals n+m of the feeding multiplier); two's-complement signed
AW, 16, accumulator width in bits; AW >= PW+1
CW, 8, run-length counter width; maximum run length 2^CW-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run; honoured only in IDLE
len  input  CW  number of products in the run; sampled on the accepted start
p_valid  input  1  product available from the multiplier stage
p_data  input  PW  signed product, two's complement
p_ready  output  1  accumulator accepts a product this cycle
acc_valid  output  1  final sum available
acc_data  output  AW  signed accumulated sum
acc_ready  input  1  consumer takes acc_data
busy  output  1  high whenever state is not IDLE
ovf  output  1  sticky; saturation occurred during the current or last run

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; accumulator = 0; counter = 0; p_ready = 0; acc_valid = 0; acc_data = 0; busy = 0; ovf = 0. A reset asserted mid-run aborts the run immediately and discards any partial sum.
- States: IDLE, ACC, DONE (2-bit encoding). busy = (state != IDLE).
- IDLE:
  - p_ready = 0, acc_valid = 0.
  - start=1 with len != 0: clear accumulator, clear ovf, load counter = len, go to ACC.
  - start=1 with len == 0: clear accumulator, clear ovf, go directly to DONE; acc_valid is high the next cycle with acc_data = 0.
- ACC:
  - p_ready = 1 (combinational from state only; no dependence on p_valid).
  - Transfer occurs when p_valid & p_ready. On a transfer: sign-extend p_data to AW+1 bits and add it to the accumulator.
  - If the sum exceeds 2^(AW-1)-1, clamp to that value; if it is below -2^(AW-1), clamp to that value. Either clamp sets ovf=1.
  - Each transfer decrements the counter. The transfer that brings the counter to 0 moves the state to DONE.
  - Cycles with p_valid=0 are stalls: no state change.
- Latency:
  - start accepted at cycle t -> p_ready high at t+1.
  - Last transfer at cycle u -> acc_valid high at u+1; acc_data includes that last product.
- DONE:
  - acc_valid = 1 and p_ready = 0.
  - acc_data is held stable until acc_ready=1. On that handshake the state returns to IDLE the next cycle.
  - acc_valid must never drop without a handshake.
- acc_data reflects the accumulator register continuously. Consumers sample it only when acc_valid=1.
- start in ACC or DONE is ignored; len is not re-sampled.
- ovf stays set until the next accepted start clears it.
- Once saturated, later products of opposite sign move the accumulator back from the clamped value (clamp is per-addition, not latched).
- No combinational path from p_valid or acc_ready to any output.

Test Plan:
1. Basic run: start with len=3; products 0x05, 0xFD (-3), 0x0A with p_valid continuous -> p_ready high from t+1; acc_valid high the cycle after the 3rd transfer; acc_data=0x000C; ovf=0.
2. Stalls: len=2; product 0x10, then 4 idle cycles, then 0x20 -> accumulator unchanged during the gap; final acc_data=0x0030; acc_valid asserts exactly one cycle after the 0x20 transfer.
3. Saturation (AW=10): len=5, five products 0x7F -> acc_data=511 (0x1FF), ovf=1. Then len=5, five products 0x80 -> acc_data=-512 (0x200), ovf=1. A following run of len=1 with product 0x01 -> acc_data=1, ovf=0.
4. Zero length and backpressure: len=0 -> acc_valid the next cycle with acc_data=0. Hold acc_ready=0 for 4 cycles -> acc_valid and acc_data stable. Pulse acc_ready -> busy=0 the following cycle.
5. Ignored start and reset abort: start pulsed during ACC with a different len -> run completes with the original len. Separately, assert rst_n=0 mid-run after 2 of 4 products -> all outputs 0 immediately. After release, a fresh len=1 run with product 0x03 -> acc_data=3.
